// File: rtl/dino_pkg.sv
// Shared definitions for the dinosaur jump path: jump state encoding and the
// trajectory timing defaults also used by the jump ROM and the renderer.
package dino_pkg;

    localparam int TICK_DIV_DEF   = 251250;
    localparam int JUMP_LEN_DEF   = 51;
    localparam int ADDR_W_DEF     = 10;
    localparam int DEB_CYCLES_DEF = 100000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AIR  = 2'd1,
        LAND = 2'd2
    } jump_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer followed by a stable-sample filter.
// Output flips only after DEB_CYCLES consecutive samples disagree with it; i_hold freezes it.
module btn_debounce #(
    parameter int DEB_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_hold,
    input  logic i_button,
    output logic o_button
);
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_filt;
    logic [CNT_W-1:0] r_cnt;

    // r_cnt counts down the remaining disagreeing samples before the output flips
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_filt  <= 1'b0;
            r_cnt   <= CNT_LOAD;
        end else if (!i_hold) begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_filt) begin
                r_cnt <= CNT_LOAD;
            end else if (r_cnt == '0) begin
                r_filt <= r_sync2;
                r_cnt  <= CNT_LOAD;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_button = r_filt;

endmodule

// File: rtl/jump_sequencer.sv
// Steps the jump-height ROM address through one fixed trajectory per button press.
// Define JUMP_DEBOUNCE_EN to insert btn_debounce on the button path.
//
// state | meaning
// IDLE  | on ground, waiting for an armed button rise
// AIR   | stepping movaddr every TICK_DIV cycles, button ignored
// LAND  | single cycle, movaddr=0 and jump_done pulses
module jump_sequencer
    import dino_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int JUMP_LEN   = JUMP_LEN_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              button,
    input  logic              halt,
    input  logic              gs,
    output logic [ADDR_W-1:0] movaddr,
    output logic              jumping,
    output logic              jump_done
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(JUMP_LEN - 1);

    jump_state_t       r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [PRE_W-1:0]  r_pre;
    logic              r_jumping;
    logic              r_done;
    logic              r_btn_q;
    logic              r_armed;
    logic              w_btn;
    logic              w_rise;

`ifdef JUMP_DEBOUNCE_EN
    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn_debounce (
        .clk      (clk),
        .reset    (reset),
        .i_hold   (halt),
        .i_button (button),
        .o_button (w_btn)
    );
`else
    logic w_unused_deb;
    assign w_unused_deb = (DEB_CYCLES != 0);
    assign w_btn        = button;
`endif

    assign w_rise = w_btn & ~r_btn_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_pre     <= '0;
            r_jumping <= 1'b0;
            r_done    <= 1'b0;
            r_btn_q   <= 1'b0;
            r_armed   <= 1'b1;
        end else if (!gs) begin
            // abort outranks everything, including a rise in the same cycle
            r_state   <= IDLE;
            r_addr    <= '0;
            r_pre     <= '0;
            r_jumping <= 1'b0;
            r_done    <= 1'b0;
            r_btn_q   <= w_btn;
            r_armed   <= ~w_btn;
        end else if (halt) begin
            r_done <= 1'b0;
        end else begin
            r_btn_q <= w_btn;
            r_done  <= 1'b0;
            if (w_rise) begin
                r_armed <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (!w_btn) begin
                        r_armed <= 1'b1;
                    end
                    if (w_rise && r_armed) begin
                        r_state   <= AIR;
                        r_addr    <= '0;
                        r_pre     <= '0;
                        r_jumping <= 1'b1;
                    end
                end
                AIR: begin
                    if (r_pre == PRE_LAST) begin
                        r_pre <= '0;
                        if (r_addr == ADDR_LAST) begin
                            r_state   <= LAND;
                            r_addr    <= '0;
                            r_jumping <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                end
                LAND: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state   <= IDLE;
                    r_addr    <= '0;
                    r_pre     <= '0;
                    r_jumping <= 1'b0;
                end
            endcase
        end
    end

    assign movaddr   = r_addr;
    assign jumping   = r_jumping;
    assign jump_done = r_done;

endmodule

// File: tb/tb_jump_sequencer.sv
// Bench for jump_sequencer: per-cycle scoreboard against a trajectory-level model,
// directed test-plan scenarios plus randomized button/halt/gs traffic.
module tb_jump_sequencer;
    localparam int TD      = 4;
    localparam int JL      = 5;
    localparam int AW      = 10;
    localparam int DEB     = 8;
    localparam int AIRTIME = TD * JL;

    logic          clk = 1'b0;
    logic          reset;
    logic          button;
    logic          halt;
    logic          gs;
    logic [AW-1:0] movaddr;
    logic          jumping;
    logic          jump_done;

    always #5 clk = ~clk;

    jump_sequencer #(
        .TICK_DIV  (TD),
        .JUMP_LEN  (JL),
        .ADDR_W    (AW),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .button   (button),
        .halt     (halt),
        .gs       (gs),
        .movaddr  (movaddr),
        .jumping  (jumping),
        .jump_done(jump_done)
    );

    typedef struct {
        int   addr;
        logic jmp;
        logic done;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   sb_en = 1'b1;

    // model: a jump is "elapsed air cycles since take-off"; address is elapsed/TD
    bit m_air, m_land, m_prev, m_released;
    int m_t;
    int n_done_exp = 0;
    int n_done_seen = 0;
    int run_len = 0;
    int last_air = 0;
    bit any_jump = 1'b0;

    function automatic void model_reset();
        m_air = 0; m_land = 0; m_prev = 0; m_released = 1; m_t = 0;
    endfunction

    function automatic void model_step(input logic b, input logic h, input logic g);
        exp_t e;
        bit   rise;
        if (!g) begin
            m_air = 0; m_land = 0; m_t = 0; m_prev = b; m_released = !b;
        end else if (!h) begin
            rise   = b && !m_prev;
            m_prev = b;
            if (m_land) begin
                m_land = 0;
            end else if (m_air) begin
                m_t++;
                if (m_t == AIRTIME) begin
                    m_air = 0; m_land = 1; m_t = 0;
                end
            end else begin
                if (rise && m_released) begin
                    m_air = 1; m_t = 0;
                end
                if (!b) m_released = 1;
            end
            if (rise) m_released = 0;
        end
        e.addr = m_air ? (m_t / TD) : 0;
        e.jmp  = m_air;
        e.done = m_land && g && !h;
        if (e.done) n_done_exp++;
        sb_q.push_back(e);
    endfunction

    task automatic cyc(input logic b, input logic h, input logic g);
        button = b; halt = h; gs = g;
        @(posedge clk);
        if (sb_en) model_step(b, h, g);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            run_len = 0;
        end else begin
            if (jumping) begin
                run_len++;
                any_jump = 1'b1;
            end else if (run_len != 0) begin
                last_air = run_len;
                run_len  = 0;
            end
            if (jump_done) n_done_seen++;
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (int'(movaddr) != e.addr || jumping !== e.jmp || jump_done !== e.done) begin
                errors++;
                $display("FAIL scoreboard @%0t: movaddr/jumping/jump_done got %0d/%0b/%0b expected %0d/%0b/%0b",
                         $time, movaddr, jumping, jump_done, e.addr, e.jmp, e.done);
            end
        end
    end

    initial begin
        int done_before;
        int first_k;
        logic rb;
        int hold;

        model_reset();
        reset = 1'b0; button = 1'b0; halt = 1'b0; gs = 1'b1;
        #1;
        chk("reset_movaddr", int'(movaddr), 0);
        chk("reset_jumping", int'(jumping), 0);
        chk("reset_jump_done", int'(jump_done), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

`ifdef JUMP_DEBOUNCE_EN
        sb_en = 1'b0;
        repeat (3) cyc(0, 0, 1);
        any_jump = 1'b0;
        repeat (5) cyc(1, 0, 1);
        repeat (25) cyc(0, 0, 1);
        chk("deb_glitch_ignored", int'(any_jump), 0);
        first_k = -1;
        for (int k = 1; k <= 40; k++) begin
            cyc((k <= 12) ? 1'b1 : 1'b0, 0, 1);
            if (jumping && first_k < 0) first_k = k;
        end
        chk("deb_press_latency", first_k, 11);
        repeat (10) cyc(0, 0, 1);
        chk("deb_jump_done_count", n_done_seen, 1);
`else
        repeat (3) cyc(0, 0, 1);

        // single one-cycle press
        cyc(1, 0, 1);
        repeat (25) cyc(0, 0, 1);
        chk("single_airtime", last_air, AIRTIME);
        chk("single_done_count", n_done_seen, 1);

        // held button: one jump only, re-press gives a second
        repeat (100) cyc(1, 0, 1);
        chk("held_done_count", n_done_seen, 2);
        repeat (5) cyc(0, 0, 1);
        cyc(1, 0, 1);
        repeat (25) cyc(0, 0, 1);
        chk("repress_done_count", n_done_seen, 3);

        // halt 7 cycles while movaddr=2
        cyc(1, 0, 1);
        repeat (10) cyc(0, 0, 1);
        chk("halt_at_addr2", int'(movaddr), 2);
        repeat (7) cyc(0, 1, 1);
        chk("halt_held_addr", int'(movaddr), 2);
        repeat (30) cyc(0, 0, 1);
        chk("halt_airtime", last_air, AIRTIME + 7);

        // abort while movaddr=3
        done_before = n_done_seen;
        cyc(1, 0, 1);
        repeat (13) cyc(0, 0, 1);
        chk("abort_at_addr3", int'(movaddr), 3);
        cyc(0, 0, 0);
        chk("abort_movaddr", int'(movaddr), 0);
        chk("abort_jumping", int'(jumping), 0);
        repeat (10) cyc(0, 0, 1);
        chk("abort_no_done", n_done_seen, done_before);

        // asynchronous reset mid-jump
        done_before = n_done_seen;
        cyc(1, 0, 1);
        repeat (8) cyc(0, 0, 1);
        reset = 1'b0;
        #1;
        chk("rst_mid_movaddr", int'(movaddr), 0);
        chk("rst_mid_jumping", int'(jumping), 0);
        chk("rst_mid_jump_done", int'(jump_done), 0);
        sb_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 0, 1);
        cyc(1, 0, 1);
        chk("rst_fresh_addr", int'(movaddr), 0);
        chk("rst_fresh_jumping", int'(jumping), 1);
        repeat (25) cyc(0, 0, 1);
        chk("rst_no_extra_done", n_done_seen, done_before + 1);
        chk("rst_fresh_airtime", last_air, AIRTIME);

        // randomized traffic
        rb = 1'b0;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                rb   = ~rb;
                hold = rb ? $urandom_range(1, 30) : $urandom_range(1, 40);
            end
            hold--;
            cyc(rb, ($urandom_range(0, 9) == 0), ($urandom_range(0, 79) != 0));
        end
        repeat (40) cyc(0, 0, 1);
        @(negedge clk);
        #1;
        chk("done_count_total", n_done_seen, n_done_exp);
        chk("scoreboard_drained", sb_q.size(), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jump_sequencer.md
# jump_sequencer

Sequences the dinosaur's jump by stepping the jump-height ROM address from a single button press through a fixed-length trajectory and back to ground. It sits between the jump button input and the jump-height ROM, and replaces free-running address stepping with an explicit idle/air/land state machine. It obeys the game-level `halt` (freeze) and `gs` (game running) controls and reports jump status to the collision and score logic.

## Interface
- `TICK_DIV`, 251250: clock cycles each ROM address is held (one step period).
- `JUMP_LEN`, 51: number of ROM entries in one jump, addresses 0..JUMP_LEN-1.
- `ADDR_W`, 10: width of `movaddr`.
- `DEB_CYCLES`, 100000: stable-sample count for the button filter (only used with `JUMP_DEBOUNCE_EN`).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `button`  in  1  jump button, level.
- `halt`  in  1  1 = freeze all state (game paused or collided).
- `gs`  in  1  1 = game running; 0 = abort any jump and force ground.
- `movaddr`  out  ADDR_W  jump ROM address; 0 = ground.
- `jumping`  out  1  high while in AIR.
- `jump_done`  out  1  one-cycle pulse on landing.

## Operation
- States: IDLE, AIR, LAND. Reset value: state IDLE, `movaddr`=0, prescaler=0, `jumping`=0, `jump_done`=0, button edge register=0, `armed`=1.
- Priority per cycle: `gs`=0 > `halt`=1 > normal operation.
- `gs`=0: next state IDLE, `movaddr`=0, prescaler=0, `jump_done`=0. Button edges are ignored. `armed` follows `~button`.
- `halt`=1 with `gs`=1: every register holds, including the edge register. No edge is generated across the halt. `jump_done` is forced to 0.
- Edge detect: `rise = btn & ~btn_q`, where `btn` is the raw or filtered button. `armed` clears on the rise and sets when `btn`=0 is seen in IDLE. A held button never starts a second jump.
- IDLE: on `rise & armed`, go to AIR with `movaddr`=0 and prescaler=0.
- AIR: the prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0, and then:
  - if `movaddr` == JUMP_LEN-1, go to LAND;
  - otherwise `movaddr` increments.
- AIR ignores button presses (no double jump).
- LAND: one cycle. `movaddr`=0, `jump_done`=1, then go to IDLE.
- `movaddr` never exceeds JUMP_LEN-1. The prescaler width is ceil(log2(TICK_DIV)).
- Simultaneous `rise` and `gs` 1→0: the abort wins and no jump starts.

## Timing
- `rise` is seen in cycle n. In cycle n+1, `jumping`=1 and `movaddr`=0.
- Each address k is presented for exactly TICK_DIV cycles.
- Airtime: JUMP_LEN×TICK_DIV cycles. LAND follows as one extra cycle.
- `jump_done` is asserted in the LAND cycle, which is the first cycle with `jumping`=0.
- Halted cycles stretch the jump exactly by the number of halted cycles.
- An asynchronous reset mid-jump returns all outputs to reset values immediately. `jump_done` does not pulse.

## Configuration
- `JUMP_DEBOUNCE_EN` defined:
  - `button` passes through a 2-flop synchronizer and then a filter.
  - The filter output changes only after DEB_CYCLES consecutive equal samples.
  - Added latency is 2+DEB_CYCLES cycles.
  - `halt` freezes the filter.
- Not defined: `button` is registered once into `btn_q` and used directly. Latency from press to `jumping` is 1 cycle.

## Structure
- Shared package `dino_pkg`: the state enum (IDLE/AIR/LAND), and the `TICK_DIV`, `JUMP_LEN` and `ADDR_W` defaults shared with the jump ROM and renderer.
- Sub-module `btn_debounce`: synchronizer plus stable counter. It is instantiated only under `JUMP_DEBOUNCE_EN`.

## Test plan
All scenarios use TICK_DIV=4, JUMP_LEN=5, with the macro undefined unless noted.
- Single jump: press `button` for 1 cycle.
  - Expect `jumping` for 20 cycles.
  - Expect `movaddr` sequence 0,1,2,3,4, each held 4 cycles.
  - Then `jump_done` pulses once and `movaddr`=0.
- Held button: hold `button` for 100 cycles. Expect exactly one jump, and no new jump until release and press again.
- Halt: assert `halt` for 7 cycles while `movaddr`=2. Expect `movaddr` held at 2 and airtime 27 cycles.
- Abort: drop `gs` while `movaddr`=3. Expect `movaddr`=0 and `jumping`=0 next cycle, with no `jump_done`.
- Reset mid-jump: drive `reset` low asynchronously. Expect outputs zero at once; after release, a press starts a fresh jump from address 0.
- Debounce (macro on, DEB_CYCLES=8):
  - A 5-cycle glitch on `button` is ignored.
  - A 12-cycle press starts a jump 10 cycles after the press begins.
